// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
//   Valid/ready word stream between the host/UART bridge and the program
//   loader.
//
//   Signals
//     in_data   stream word, driven by the master
//     in_valid  in_data is valid, driven by the master
//     in_ready  the loader can take a word, driven by the slave
//   A word transfers on a rising clock edge where in_valid & in_ready.
//
//   Modports
//     master  host side   (drives in_data/in_valid)
//     slave   loader side (drives in_ready)
// ----------------------------------------------------------------------------
interface program_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
//   Boot stage for the 16-bit accumulator CPU.
//
//   The loader takes framed words from a valid/ready stream and turns them
//   into write strobes for the CPU instruction and data memories. It also
//   owns the CPU reset. The CPU stays in reset while memory is loaded. A RUN
//   word releases it, so the program counter starts at 0 on fresh memory.
//
//   Frame format
//     header word
//       bit15    target: 0 = instruction memory, 1 = data memory
//       bit14    must be 0
//       [12:8]   payload word count - 1
//       [4:0]    start address (data memory uses [3:0])
//     payload   count words. The address wraps modulo the memory depth.
//     16'hFFFF  RUN: release the CPU.
//     16'hFFFE  STOP: put the CPU back in reset. In HEADER state it does nothing.
//
//   Optional feature: LOADER_CHECKSUM_EN
//     When this macro is defined, each frame ends with one extra check word.
//     The check word must equal the XOR of the frame's payload; a mismatch
//     sets err. The frame's writes are not undone. A RUN word is refused
//     while err is set.
//
//   Ports
//     clk                 system clock, rising edge
//     reset               synchronous, active-high
//     stream              program_loader_if.slave (in_data/in_valid/in_ready)
//     instruction_input   instruction word to write
//     load_instr_address  instruction write address
//     load_instr          instruction write strobe, 1 cycle
//     data_input          data word to write
//     load_data_address   data write address
//     load_data           data write strobe, 1 cycle
//     cpu_reset           1 = CPU held in reset
//     running             1 while the CPU runs
//     err                 sticky error flag, cleared only by reset
// ----------------------------------------------------------------------------
module program_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int IADDR_WIDTH = 5,
    parameter int DADDR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    program_loader_if.slave        stream,
    output logic [DATA_WIDTH-1:0]  instruction_input,
    output logic [IADDR_WIDTH-1:0] load_instr_address,
    output logic                   load_instr,
    output logic [DATA_WIDTH-1:0]  data_input,
    output logic [DADDR_WIDTH-1:0] load_data_address,
    output logic                   load_data,
    output logic                   cpu_reset,
    output logic                   running,
    output logic                   err
);

    localparam logic [DATA_WIDTH-1:0] RUN_WORD  = '1;
    localparam logic [DATA_WIDTH-1:0] STOP_WORD = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
    localparam int TGT_BIT = DATA_WIDTH - 1;
    localparam int RSV_BIT = DATA_WIDTH - 2;
    localparam int CNT_LSB = 8;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1,
        S_RUN     = 2'd2
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK = 2'd3
`endif
    } state_t;

    state_t                  state, state_nxt;
    logic                    rdy_q;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   word;
    logic                    is_run, is_stop, run_ok;
    logic                    tgt_data_q;
    logic [IADDR_WIDTH-1:0]  remain_q;   // payload words still to come, minus one
    logic [IADDR_WIDTH-1:0]  addr_q;     // next write address (data uses low bits)
    logic                    err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   xor_q;
`endif

    assign word    = stream.in_data;
    assign accept  = stream.in_valid & rdy_q;
    assign is_run  = (word == RUN_WORD);
    assign is_stop = (word == STOP_WORD);

`ifdef LOADER_CHECKSUM_EN
    assign run_ok = ~err_q;
`else
    assign run_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HEADER;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_HEADER: begin
                if (accept) begin
                    if (is_run) begin
                        if (run_ok) state_nxt = S_RUN;
                    end else if (!is_stop && !word[RSV_BIT]) begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept && remain_q == '0) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_HEADER;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) state_nxt = S_HEADER;
            end
`endif
            S_RUN: begin
                if (accept && is_stop) state_nxt = S_HEADER;
            end
            default: state_nxt = S_HEADER;
        endcase
    end

    // State-decoded outputs. cpu_reset follows the state register, so it
    // rises on the same edge that leaves RUN.
    always_comb begin
        cpu_reset       = (state != S_RUN);
        running         = (state == S_RUN);
        stream.in_ready = rdy_q;
        err             = err_q;
    end

    // Frame bookkeeping and registered write ports. Each write strobe is high
    // for exactly the cycle after the word is accepted. The data and address
    // outputs keep their last value between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q              <= 1'b0;
            err_q              <= 1'b0;
            tgt_data_q         <= 1'b0;
            remain_q           <= '0;
            addr_q             <= '0;
            load_instr         <= 1'b0;
            load_data          <= 1'b0;
            instruction_input  <= '0;
            load_instr_address <= '0;
            data_input         <= '0;
            load_data_address  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q              <= '0;
`endif
        end else begin
            rdy_q      <= 1'b1;
            load_instr <= 1'b0;
            load_data  <= 1'b0;
            if (accept) begin
                case (state)
                    S_HEADER: begin
                        if (!is_run && !is_stop) begin
                            if (word[RSV_BIT]) begin
                                err_q <= 1'b1;
                            end else begin
                                tgt_data_q <= word[TGT_BIT];
                                remain_q   <= word[CNT_LSB +: IADDR_WIDTH];
                                addr_q     <= word[IADDR_WIDTH-1:0];
`ifdef LOADER_CHECKSUM_EN
                                xor_q      <= '0;
`endif
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        addr_q   <= addr_q + IADDR_WIDTH'(1);
                        remain_q <= remain_q - IADDR_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                        xor_q    <= xor_q ^ word;
`endif
                        if (tgt_data_q) begin
                            load_data         <= 1'b1;
                            data_input        <= word;
                            load_data_address <= addr_q[DADDR_WIDTH-1:0];
                        end else begin
                            load_instr         <= 1'b1;
                            instruction_input  <= word;
                            load_instr_address <= addr_q;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (word != xor_q) err_q <= 1'b1;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
//   Directed bench for program_loader. A word-level reference model runs in
//   the bench. A compare process checks every DUT output against it on each
//   falling edge. Hand-computed literal checks pin the key scenarios.
//   Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the
//   checksum build.
// ----------------------------------------------------------------------------
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction_input, data_input;
    logic [4:0]  load_instr_address;
    logic [3:0]  load_data_address;
    logic        load_instr, load_data, cpu_reset, running, err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    program_loader_if #(.DATA_WIDTH(16)) bus ();

    program_loader dut (
        .clk                (clk),
        .reset              (reset),
        .stream             (bus),
        .instruction_input  (instruction_input),
        .load_instr_address (load_instr_address),
        .load_instr         (load_instr),
        .data_input         (data_input),
        .load_data_address  (load_data_address),
        .load_data          (load_data),
        .cpu_reset          (cpu_reset),
        .running            (running),
        .err                (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (word level) ----------------
    localparam int MH = 0, MP = 1, MR = 2, MC = 3;
    bit          m_valid = 0;
    int          m_mode, m_left, m_addr;
    bit          m_tgt;
    logic [15:0] m_xor;
    logic        e_li, e_ld, e_err, e_ready;
    logic [15:0] e_id, e_dd;
    logic [4:0]  e_ia;
    logic [3:0]  e_da;
    bit          m_cks;

    initial begin
`ifdef LOADER_CHECKSUM_EN
        m_cks = 1;
`else
        m_cks = 0;
`endif
    end

    always @(posedge clk) begin
        logic        acc;
        logic [15:0] w;
        if (reset) begin
            m_valid = 1; m_mode = MH; m_left = 0; m_addr = 0; m_tgt = 0; m_xor = '0;
            e_li = 0; e_ld = 0; e_err = 0; e_ready = 0;
            e_id = '0; e_dd = '0; e_ia = '0; e_da = '0;
        end else if (m_valid) begin
            acc  = bus.in_valid && e_ready;
            w    = bus.in_data;
            e_li = 0;
            e_ld = 0;
            if (acc) begin
                if (m_mode == MH) begin
                    if (w == 16'hFFFF) begin
                        if (!(m_cks && e_err)) m_mode = MR;
                    end else if (w == 16'hFFFE) begin
                        m_mode = MH;
                    end else if (w[14]) begin
                        e_err = 1;
                    end else begin
                        m_tgt  = w[15];
                        m_left = int'(w[12:8]) + 1;
                        m_addr = int'(w[4:0]);
                        m_xor  = '0;
                        m_mode = MP;
                    end
                end else if (m_mode == MP) begin
                    if (m_tgt) begin
                        e_ld = 1; e_dd = w; e_da = 4'(m_addr % 16);
                    end else begin
                        e_li = 1; e_id = w; e_ia = 5'(m_addr % 32);
                    end
                    m_addr = (m_addr + 1) % 32;
                    m_xor  = m_xor ^ w;
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = m_cks ? MC : MH;
                end else if (m_mode == MC) begin
                    if (w != m_xor) e_err = 1;
                    m_mode = MH;
                end else begin
                    if (w == 16'hFFFE) m_mode = MH;
                end
            end
            e_ready = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("in_ready",  32'(bus.in_ready), 32'(e_ready));
            chk("load_instr", 32'(load_instr), 32'(e_li));
            chk("load_data",  32'(load_data),  32'(e_ld));
            chk("instr_in",   32'(instruction_input), 32'(e_id));
            chk("instr_addr", 32'(load_instr_address), 32'(e_ia));
            chk("data_in",    32'(data_input), 32'(e_dd));
            chk("data_addr",  32'(load_data_address), 32'(e_da));
            chk("cpu_reset",  32'(cpu_reset), 32'(m_mode != MR));
            chk("running",    32'(running), 32'(m_mode == MR));
            chk("err",        32'(err), 32'(e_err));
            chk("one_strobe", 32'(load_instr & load_data), 32'(0));
            chk("no_wr_run",  32'((load_instr | load_data) & running), 32'(0));
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] pl [0:31];

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send(input logic [15:0] w);
        int budget = 20;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL handshake: in_ready stuck 0 for word %0h", w);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] hdr, input int n);
        logic [15:0] x = '0;
        send(hdr);
        for (int i = 0; i < n; i++) begin
            send(pl[i]);
            x = x ^ pl[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send(x);
`endif
    endtask

    task automatic idle(input int k);
        bus.in_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        // 1: reset held 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("t1_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t1_load_instr", 32'(load_instr), 32'd0);
        chk("t1_load_data", 32'(load_data), 32'd0);
        chk("t1_running", 32'(running), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_ready_in_reset", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t1_ready_after", 32'(bus.in_ready), 32'd1);

        // 2: instruction frame, 4 words back-to-back at address 0
        pl[0] = 16'h1111; pl[1] = 16'h2222; pl[2] = 16'h3333; pl[3] = 16'h4444;
        send_frame(16'h0300, 4);
        chk("t2_addr", 32'(load_instr_address), 32'd3);
        chk("t2_data", 32'(instruction_input), 32'h4444);

        // 3: data frame of 4 from address 14 wraps 14,15,0,1
        pl[0] = 16'hA001; pl[1] = 16'hA002; pl[2] = 16'hA003; pl[3] = 16'hA004;
        send_frame(16'h830E, 4);
        chk("t3_addr", 32'(load_data_address), 32'd1);
        chk("t3_data", 32'(data_input), 32'hA004);
        chk("t3_err", 32'(err), 32'd0);

        // instruction address wrap 31 -> 0
        pl[0] = 16'hBEEF; pl[1] = 16'hCAFE;
        send_frame(16'h011F, 2);
        chk("iwrap_addr", 32'(load_instr_address), 32'd0);
        chk("iwrap_data", 32'(instruction_input), 32'hCAFE);

        // in_valid gap mid-frame holds the frame
        send(16'h0201);
        send(16'h0001);
        idle(5);
        send(16'h0002);
        send(16'h0003);
`ifdef LOADER_CHECKSUM_EN
        send(16'h0000);
`endif
        chk("gap_addr", 32'(load_instr_address), 32'd3);
        chk("gap_data", 32'(instruction_input), 32'h0003);

        // 4: RUN, discarded word, STOP
        send(16'hFFFF);
        chk("t4_running", 32'(running), 32'd1);
        chk("t4_cpu_reset", 32'(cpu_reset), 32'd0);
        send(16'h1234);
        chk("t4_no_strobe", 32'(load_instr | load_data), 32'd0);
        chk("t4_still_run", 32'(running), 32'd1);
        send(16'hFFFE);
        chk("t4_stop_reset", 32'(cpu_reset), 32'd1);
        chk("t4_stop_run", 32'(running), 32'd0);

        // STOP in HEADER is a no-op
        send(16'hFFFE);
        idle(2);

        // 5: bad header sets err, next header loads normally
        send(16'h4000);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_no_strobe", 32'(load_instr | load_data), 32'd0);
        pl[0] = 16'hABCD;
        send_frame(16'h0005, 1);
        chk("t5_addr", 32'(load_instr_address), 32'd5);
        chk("t5_data", 32'(instruction_input), 32'hABCD);
        send(16'hFFFF);
`ifdef LOADER_CHECKSUM_EN
        chk("t5_run_refused", 32'(cpu_reset), 32'd1);
`else
        chk("t5_run_ok", 32'(running), 32'd1);
        send(16'hFFFE);
`endif

        // reset mid-frame aborts the frame
        send(16'h0300);
        send(16'h7777);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_strobe", 32'(load_instr), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        pl[0] = 16'h5555;
        send_frame(16'h0000, 1);
        chk("rst_mid_addr", 32'(load_instr_address), 32'd0);
        chk("rst_mid_data", 32'(instruction_input), 32'h5555);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum good, then bad, then RUN refused
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send(16'h0100); send(16'h00F0); send(16'h000F); send(16'h00FF);
        chk("t6_good_err", 32'(err), 32'd0);
        send(16'h0100); send(16'h00F0); send(16'h000F); send(16'h0000);
        chk("t6_bad_err", 32'(err), 32'd1);
        chk("t6_writes_stand", 32'(instruction_input), 32'h000F);
        send(16'hFFFF);
        chk("t6_run_refused", 32'(cpu_reset), 32'd1);
        chk("t6_not_running", 32'(running), 32'd0);
`endif

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
